// File: rtl/roll_sequencer.sv
// roll_sequencer
// Sits between the raw launch push-button and the random-counter stage of the
// dice launcher. The button is synchronised and debounced. Each clean press
// starts a decelerating "rolling" animation: the free-running random value
// ValCPT is sampled onto Result at growing intervals. The last sample is then
// frozen, Done pulses for one cycle, and the block waits for the button to be
// released before it accepts another press.

// Protocol checker for the roll outputs; instantiated by roll_sequencer.
module roll_sequencer_checker (
    input logic clk_i,
    input logic reset_i,
    input logic rolling_i,
    input logic done_i
);

    // Done marks the freeze of the final value, so the animation is over by then
    a_done_not_rolling: assert property (@(posedge clk_i) disable iff (reset_i)
        done_i |-> !rolling_i);

    // Done is a single-cycle pulse
    a_done_one_cycle: assert property (@(posedge clk_i) disable iff (reset_i)
        done_i |=> !done_i);

endmodule

module roll_sequencer #(
    parameter int unsigned DEB_CYCLES = 32'd500000,
    parameter int unsigned N_STEPS    = 32'd12,
    parameter int unsigned STEP_INIT  = 32'd2500000,
    parameter int unsigned STEP_INC   = 32'd1250000,
    parameter int unsigned VAL_W      = 32'd7
) (
    input  logic             ClkIn,
    input  logic             Reset,
    input  logic             BLancer,
    input  logic [VAL_W-1:0] ValCPT,
    output logic [VAL_W-1:0] Result,
    output logic             Rolling,
    output logic             Done
);

    // Debounce counter wide enough to reach DEB_CYCLES-1 with headroom.
    localparam int DCW = $clog2(DEB_CYCLES) + 32'd1;

    // Longest interval between updates: used by the final step.
    localparam longint unsigned MAX_INTERVAL =
        64'(STEP_INIT) + (64'(N_STEPS - 32'd1) * 64'(STEP_INC));

    // Timer and interval share one width that holds MAX_INTERVAL.
    localparam int TW_RAW = $clog2(MAX_INTERVAL + 64'd1);
    localparam int TW     = (TW_RAW < 32'd1) ? 32'd1 : TW_RAW;

    // Step index counts 0 .. N_STEPS-1.
    localparam int KW = (N_STEPS > 32'd1) ? $clog2(N_STEPS) : 32'd1;

    localparam logic [DCW-1:0] DEB_LAST = DCW'(DEB_CYCLES - 32'd1);
    localparam logic [TW-1:0]  INIT_V   = TW'(STEP_INIT);
    localparam logic [TW-1:0]  INC_V    = TW'(STEP_INC);
    localparam logic [KW-1:0]  K_LAST   = KW'(N_STEPS - 32'd1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ROLL = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    // Input conditioning
    logic           sync1_q;
    logic           sync2_q;
    logic           deb_q;
    logic           deb_d;
    logic           deb_prev_q;
    logic [DCW-1:0] dcnt_q;
    logic [DCW-1:0] dcnt_d;
    logic           press_s;

    // Roll control
    state_e         state_q;
    state_e         state_d;
    logic [TW-1:0]  timer_q;
    logic [TW-1:0]  timer_d;
    logic [TW-1:0]  interval_q;
    logic [TW-1:0]  interval_d;
    logic [KW-1:0]  k_q;
    logic [KW-1:0]  k_d;
    logic [VAL_W-1:0] result_q;
    logic [VAL_W-1:0] result_d;
    logic           rolling_q;
    logic           rolling_d;
    logic           done_q;
    logic           done_d;

    // Debounce: accept a new level only after DEB_CYCLES consecutive mismatching samples
    always_comb begin
        deb_d  = deb_q;
        dcnt_d = dcnt_q;
        if (sync2_q != deb_q) begin
            if (dcnt_q == DEB_LAST) begin
                deb_d  = sync2_q;
                dcnt_d = {DCW{1'b0}};
            end else begin
                dcnt_d = dcnt_q + DCW'(1'b1);
            end
        end else begin
            dcnt_d = {DCW{1'b0}};
        end
    end

    // Two-flop synchroniser, debounced level and its one-cycle-delayed copy
    always_ff @(posedge ClkIn) begin
        if (Reset) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            deb_q      <= 1'b0;
            deb_prev_q <= 1'b0;
            dcnt_q     <= {DCW{1'b0}};
        end else begin
            sync1_q    <= BLancer;
            sync2_q    <= sync1_q;
            deb_q      <= deb_d;
            deb_prev_q <= deb_q;
            dcnt_q     <= dcnt_d;
        end
    end

    // A press is the single cycle in which the debounced level has just risen.
    assign press_s = deb_q & ~deb_prev_q;

    // Roll FSM next state: IDLE waits for a press, ROLL samples at growing
    // intervals, HOLD freezes the result until the button is released
    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        interval_d = interval_q;
        k_d        = k_q;
        result_d   = result_q;
        done_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (press_s) begin
                    state_d    = ST_ROLL;
                    timer_d    = {TW{1'b0}};
                    k_d        = {KW{1'b0}};
                    interval_d = INIT_V;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ROLL: begin
                // A press event seen here is dropped: one physical press, one roll.
                if (timer_q == (interval_q - TW'(1'b1))) begin
                    result_d = ValCPT;
                    timer_d  = {TW{1'b0}};
                    if (k_q == K_LAST) begin
                        state_d = ST_HOLD;
                        done_d  = 1'b1;
                    end else begin
                        k_d        = k_q + KW'(1'b1);
                        interval_d = interval_q + INC_V;
                    end
                end else begin
                    timer_d = timer_q + TW'(1'b1);
                end
            end
            ST_HOLD: begin
                if (!deb_q) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                timer_d    = {TW{1'b0}};
                interval_d = {TW{1'b0}};
                k_d        = {KW{1'b0}};
            end
        endcase
        rolling_d = (state_d == ST_ROLL);
    end

    // Roll FSM state, counters and registered outputs; reset wins over a roll in progress
    always_ff @(posedge ClkIn) begin
        if (Reset) begin
            state_q    <= ST_IDLE;
            timer_q    <= {TW{1'b0}};
            interval_q <= {TW{1'b0}};
            k_q        <= {KW{1'b0}};
            result_q   <= {VAL_W{1'b0}};
            rolling_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            interval_q <= interval_d;
            k_q        <= k_d;
            result_q   <= result_d;
            rolling_q  <= rolling_d;
            done_q     <= done_d;
        end
    end

    assign Result  = result_q;
    assign Rolling = rolling_q;
    assign Done    = done_q;

    roll_sequencer_checker u_checker (
        .clk_i     (ClkIn),
        .reset_i   (Reset),
        .rolling_i (rolling_q),
        .done_i    (done_q)
    );

endmodule
